// File: rtl/led_pio_sequencer_if.sv
// Bus bundle for the LED PIO sequencer. It carries the configuration slave
// port, the write-only PIO master port and the interrupt line.
// The slave modport is the sequencer's side. The master modport is the
// CPU/system side, which drives configuration and observes the PIO traffic.
interface led_pio_sequencer_if;
  logic [2:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  modport slave (
    input  s_address, s_chipselect, s_write_n, s_writedata,
    output s_readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );

  modport master (
    output s_address, s_chipselect, s_write_n, s_writedata,
    input  s_readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );
endinterface

// File: rtl/led_pio_sequencer.sv
// LED PIO sequencer. It holds a small table of LED patterns and a dwell
// period. It replays the table onto the PIO data register either once or in
// a loop, and it flags completion of a single-shot run through a level
// interrupt.
module led_pio_sequencer #(
  parameter int DATA_WIDTH   = 4,
  parameter int NUM_STEPS    = 4,
  parameter int PERIOD_WIDTH = 24
) (
  input logic               clk,
  input logic               reset_n,
  led_pio_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;

  localparam logic [2:0] NSTEPS3   = 3'(NUM_STEPS);
  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  state_t                  state_q;
  logic                    run_q, loop_q, irq_en_q, done_q;
  logic [1:0]              step_q;
  logic [PERIOD_WIDTH-1:0] period_q, cnt_q;
  logic [DATA_WIDTH-1:0]   pattern_q [4];
  logic                    m_cs_q, m_wr_n_q;
  logic [DATA_WIDTH-1:0]   m_wd_q;

  logic                    wr, wr_ctrl, wr_stat, wr_period, wr_pat;
  logic [1:0]              pat_idx;
  logic                    pat_ok;
  logic                    running;
  logic                    last_step;
  logic [1:0]              step_nx;
  logic [PERIOD_WIDTH-1:0] period_eff;
  logic [31:0]             rdata;
  logic                    unused_wdata;

  assign wr        = bus.s_chipselect & ~bus.s_write_n;
  assign pat_idx   = bus.s_address[1:0];
  assign pat_ok    = bus.s_address[2] && ({1'b0, pat_idx} < NSTEPS3);
  assign wr_ctrl   = wr && (bus.s_address == 3'd0);
  assign wr_stat   = wr && (bus.s_address == 3'd1);
  assign wr_period = wr && (bus.s_address == 3'd2);
  assign wr_pat    = wr && pat_ok;

  // A zero period dwells for one cycle, just as a period of one does.
  assign period_eff = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;
  assign last_step  = (step_q == LAST_STEP);
  assign step_nx    = last_step ? 2'd0 : step_q + 2'd1;
  assign running    = (state_q != IDLE);

  assign unused_wdata = ^bus.s_writedata;

  // Pattern table and period register: plain CPU-writable storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= PERIOD_WIDTH'(1);
      for (int k = 0; k < 4; k++) pattern_q[k] <= '0;
    end else begin
      if (wr_period) period_q <= bus.s_writedata[PERIOD_WIDTH-1:0];
      if (wr_pat)    pattern_q[pat_idx] <= bus.s_writedata[DATA_WIDTH-1:0];
    end
  end

  // Control/status registers and the sequencing FSM with registered PIO strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= 2'd0;
      cnt_q    <= '0;
      m_cs_q   <= 1'b0;
      m_wr_n_q <= 1'b1;
      m_wd_q   <= '0;
    end else begin
      m_cs_q   <= 1'b0;
      m_wr_n_q <= 1'b1;
      if (wr_ctrl) begin
        run_q    <= bus.s_writedata[0];
        loop_q   <= bus.s_writedata[1];
        irq_en_q <= bus.s_writedata[2];
      end
      // The FSM's own set of done below overrides this clear.
      if (wr_stat && bus.s_writedata[1]) done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // Start on the very edge that registers run, so LOAD follows at once.
          if (wr_ctrl && bus.s_writedata[0]) begin
            state_q  <= LOAD;
            step_q   <= 2'd0;
            cnt_q    <= period_eff;
            m_cs_q   <= 1'b1;
            m_wr_n_q <= 1'b0;
            m_wd_q   <= pattern_q[0];
          end
        end
        LOAD: begin
          if (wr_ctrl && !bus.s_writedata[0]) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
          end else begin
            state_q <= DWELL;
          end
        end
        DWELL: begin
          if (wr_ctrl && !bus.s_writedata[0]) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
          end else if (cnt_q == PERIOD_WIDTH'(1)) begin
            if (!last_step || loop_q) begin
              state_q  <= LOAD;
              step_q   <= step_nx;
              cnt_q    <= period_eff;
              m_cs_q   <= 1'b1;
              m_wr_n_q <= 1'b0;
              m_wd_q   <= pattern_q[step_nx];
            end else begin
              state_q <= IDLE;
              step_q  <= 2'd0;
              run_q   <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - PERIOD_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Zero-wait-state read mux; idle bus reads as zero
  always_comb begin
    rdata = '0;
    if (bus.s_chipselect) begin
      case (bus.s_address)
        3'd0:    rdata = {29'd0, irq_en_q, loop_q, run_q};
        3'd1:    rdata = {26'd0, step_q, 2'b00, done_q, running};
        3'd2:    rdata = 32'(period_q);
        default: if (pat_ok) rdata = 32'(pattern_q[pat_idx]);
      endcase
    end
  end

  assign bus.s_readdata   = rdata;
  assign bus.m_address    = 2'd0;
  assign bus.m_chipselect = m_cs_q;
  assign bus.m_write_n    = m_wr_n_q;
  assign bus.m_writedata  = 32'(m_wd_q);
  assign bus.irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: expected PIO writes (data and
// cycle stamp) are queued by the stimulus and consumed by a monitor.
module tb_led_pio_sequencer;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb_q[$];

  led_pio_sequencer_if bus();

  led_pio_sequencer #(.DATA_WIDTH(4), .NUM_STEPS(4), .PERIOD_WIDTH(24)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every PIO write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (bus.m_chipselect && !bus.m_write_n) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got data %h at cycle %0d, expected no write",
                 bus.m_writedata, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.data !== bus.m_writedata || e.cyc != cyc || bus.m_address !== 2'd0) begin
          mismatched++;
          $display("FAIL pio_write: got data %h addr %0d cycle %0d, expected data %h addr 0 cycle %0d",
                   bus.m_writedata, bus.m_address, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    bus.s_address    = a;
    bus.s_writedata  = d;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b0;
    @(posedge clk);
    #1;
    e = cyc;
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.s_address    = a;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b1;
    #1;
    chk(name, bus.s_readdata, exp);
    bus.s_chipselect = 1'b0;
  endtask

  task automatic push(input int c, input logic [31:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic load_patterns(input logic [3:0] p0, input logic [3:0] p1,
                               input logic [3:0] p2, input logic [3:0] p3);
    int e;
    cfg_write(3'd4, 32'(p0), e);
    cfg_write(3'd5, 32'(p1), e);
    cfg_write(3'd6, 32'(p2), e);
    cfg_write(3'd7, 32'(p3), e);
  endtask

  initial begin
    int e;
    logic [31:0] pats [4];
    pats[0] = 32'h1; pats[1] = 32'h2; pats[2] = 32'h4; pats[3] = 32'h8;
    bus.s_address = 3'd0; bus.s_chipselect = 1'b0;
    bus.s_write_n = 1'b1; bus.s_writedata = 32'd0;

    // 1. Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_cs", 32'(bus.m_chipselect), 32'd0);
    chk("rst_m_write_n", 32'(bus.m_write_n), 32'd1);
    chk("rst_m_writedata", bus.m_writedata, 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_readdata", bus.s_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, 32'h0, "rst_control");
    rd(3'd1, 32'h0, "rst_status");
    rd(3'd2, 32'h1, "rst_period");
    rd(3'd3, 32'h0, "rst_reserved");
    for (int k = 0; k < 4; k++) rd(3'(4 + k), 32'h0, "rst_pattern");

    // 2. Single-shot run, PERIOD = 3, irq enabled
    load_patterns(4'h1, 4'h2, 4'h4, 4'h8);
    cfg_write(3'd2, 32'd3, e);
    rd(3'd4, 32'h1, "pattern0_rb");
    rd(3'd7, 32'h8, "pattern3_rb");
    rd(3'd2, 32'h3, "period_rb");
    cfg_write(3'd0, 32'h5, e);
    for (int k = 0; k < 4; k++) push(e + 4 * k, pats[k]);
    wait_to(e + 15);
    chk("ss_irq_before_done", 32'(bus.irq), 32'd0);
    wait_to(e + 16);
    chk("ss_irq_after_done", 32'(bus.irq), 32'd1);
    rd(3'd1, 32'h2, "ss_status_done");
    rd(3'd0, 32'h4, "ss_control_run_cleared");

    // 4a. W1C of done drops irq on that edge
    cfg_write(3'd1, 32'h2, e);
    chk("w1c_irq_drop", 32'(bus.irq), 32'd0);
    rd(3'd1, 32'h0, "w1c_status");

    // 3. Loop mode, PERIOD = 0, abort in DWELL
    cfg_write(3'd2, 32'd0, e);
    cfg_write(3'd0, 32'h3, e);
    for (int k = 0; k < 6; k++) push(e + 2 * k, pats[k % 4]);
    wait_to(e + 11);
    cfg_write(3'd0, 32'h0, e);
    repeat (10) @(posedge clk);
    rd(3'd1, 32'h0, "loop_abort_status");
    rd(3'd0, 32'h0, "loop_abort_control");
    chk("loop_queue_drained", 32'(sb_q.size()), 32'd0);

    // 4b. W1C on the same edge the FSM sets done: set wins
    cfg_write(3'd2, 32'd3, e);
    cfg_write(3'd0, 32'h5, e);
    for (int k = 0; k < 4; k++) push(e + 4 * k, pats[k]);
    wait_to(e + 15);
    cfg_write(3'd1, 32'h2, e);
    chk("w1c_collide_irq", 32'(bus.irq), 32'd1);
    rd(3'd1, 32'h2, "w1c_collide_status");
    cfg_write(3'd1, 32'h2, e);
    rd(3'd1, 32'h0, "w1c_collide_cleared");

    // 5. PATTERN[3] edited during step-1 DWELL; restart attempt ignored
    cfg_write(3'd0, 32'h1, e);
    push(e, 32'h1); push(e + 4, 32'h2); push(e + 8, 32'h4); push(e + 12, 32'hF);
    wait_to(e + 5);
    begin
      int e2;
      cfg_write(3'd7, 32'hF, e2);
      wait_to(e + 9);
      cfg_write(3'd0, 32'h1, e2);
    end
    wait_to(e + 17);
    chk("edit_irq_masked", 32'(bus.irq), 32'd0);
    rd(3'd1, 32'h2, "edit_status_done");
    cfg_write(3'd1, 32'h2, e);
    cfg_write(3'd7, 32'h8, e);

    // 6. Asynchronous reset during step-2 DWELL
    cfg_write(3'd0, 32'h1, e);
    push(e, 32'h1); push(e + 4, 32'h2); push(e + 8, 32'h4);
    wait_to(e + 9);
    reset_n = 1'b0;
    #1;
    chk("midrst_m_cs", 32'(bus.m_chipselect), 32'd0);
    chk("midrst_m_write_n", 32'(bus.m_write_n), 32'd1);
    chk("midrst_m_writedata", bus.m_writedata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    rd(3'd1, 32'h0, "midrst_status");
    rd(3'd0, 32'h0, "midrst_control");
    rd(3'd2, 32'h1, "midrst_period");
    chk("final_queue_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
